// File: rtl/store_buffer_fwd_if.sv
// SRAM-like data port bundle (req/addr_ok/data_ok) shared by the CPU side and the dcache side.
// The requester uses the master modport; the responder uses the slave modport.
interface store_buffer_fwd_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req;
  logic          wr;
  logic [1:0]    size;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic [DW-1:0] rdata;
  logic          addr_ok;
  logic          data_ok;

  modport master (
    output req, wr, size, addr, wdata, wstrb,
    input  rdata, addr_ok, data_ok
  );

  modport slave (
    input  req, wr, size, addr, wdata, wstrb,
    output rdata, addr_ok, data_ok
  );
endinterface

// File: rtl/store_buffer_fwd.sv
// Write-posting store buffer between the CPU data port and the dcache, with in-order drain.
// Optional store-to-load forwarding is compiled in with `define SB_LOAD_FORWARD_EN.

// Per-entry word-address compare against the incoming load.
module sb_ent_cmp #(
  parameter int AW = 32
) (
  input  logic          vld,
  input  logic [AW-1:0] ent_addr,
  input  logic [AW-1:0] ld_addr,
  output logic          hit
);
  assign hit = vld && (ent_addr[AW-1:2] == ld_addr[AW-1:2]);
endmodule

module store_buffer_fwd #(
  parameter int DEPTH = 8,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  store_buffer_fwd_if.slave        cpu_data,
  store_buffer_fwd_if.master       dcache_data,
  input  logic                     sb_flush_req,
  output logic                     sb_empty,
  output logic [$clog2(DEPTH):0]   sb_count
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_WAIT_LOAD  = 2'd1;
  localparam logic [1:0] ST_WAIT_STORE = 2'd2;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, cnt;
  logic [IW-1:0] wr_idx, rd_idx;
  logic [1:0]    state_q, state_d;
  logic          st_rsp_q, st_rsp_d;
  logic          full, empty, hit;
  logic          store_acc, load_grant, drain_go, pop, load_rsp;
  logic          fwd_acc, fwd_pend;
  logic [DEPTH-1:0] ent_hit;

  logic [DEPTH-1:0][AW-1:0] ent_addr_q;
  logic [DEPTH-1:0][DW-1:0] ent_wdata_q;
  logic [DEPTH-1:0][3:0]    ent_wstrb_q;
  logic [DEPTH-1:0][1:0]    ent_size_q;

  assign wr_idx = wr_ptr_q[IW-1:0];
  assign rd_idx = rd_ptr_q[IW-1:0];
  assign cnt    = wr_ptr_q - rd_ptr_q;
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[IW] != rd_ptr_q[IW]) && (wr_idx == rd_idx);

  // An entry is live when its age offset from rd_ptr is below the occupancy.
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    logic [IW-1:0] off;
    assign off = IW'(g) - rd_idx;
    sb_ent_cmp #(.AW(AW)) u_cmp (
      .vld      ({1'b0, off} < cnt),
      .ent_addr (ent_addr_q[g]),
      .ld_addr  (cpu_data.addr),
      .hit      (ent_hit[g])
    );
  end

  assign hit = |ent_hit;

`ifdef SB_LOAD_FORWARD_EN
  logic [IW-1:0] young_idx;
  logic [3:0]    ld_mask;
  logic          fwd_q, fwd_d;
  logic [DW-1:0] fwd_data_q, fwd_data_d;

  // Scan oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    young_idx = rd_idx;
    for (int k = 0; k < DEPTH; k++) begin
      if (ent_hit[rd_idx + IW'(k)]) young_idx = rd_idx + IW'(k);
    end
  end

  always_comb begin
    case (cpu_data.size)
      2'd0:    ld_mask = 4'b0001 << cpu_data.addr[1:0];
      2'd1:    ld_mask = 4'b0011 << cpu_data.addr[1:0];
      default: ld_mask = 4'b1111;
    endcase
  end

  always_comb begin
    fwd_acc    = cpu_data.req && !cpu_data.wr && hit &&
                 ((ent_wstrb_q[young_idx] & ld_mask) == ld_mask) &&
                 !sb_flush_req && (state_q != ST_WAIT_LOAD) && !fwd_q;
    fwd_d      = fwd_acc;
    fwd_data_d = fwd_acc ? ent_wdata_q[young_idx] : fwd_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_q      <= fwd_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  assign fwd_pend         = fwd_q;
  assign cpu_data.data_ok = st_rsp_q | fwd_q | load_rsp;
  assign cpu_data.rdata   = fwd_q ? fwd_data_q : dcache_data.rdata;
`else
  assign fwd_acc          = 1'b0;
  assign fwd_pend         = 1'b0;
  assign cpu_data.data_ok = st_rsp_q | load_rsp;
  assign cpu_data.rdata   = dcache_data.rdata;
`endif

  always_comb begin
    store_acc  = cpu_data.req && cpu_data.wr && !full && !sb_flush_req &&
                 (state_q != ST_WAIT_LOAD) && !fwd_pend;
    load_grant = cpu_data.req && !cpu_data.wr && !hit && (state_q == ST_IDLE) &&
                 !sb_flush_req && !st_rsp_q && !fwd_pend;
    drain_go   = (state_q == ST_IDLE) && !empty && !load_grant;
    pop        = drain_go && dcache_data.addr_ok;
    wr_ptr_d   = wr_ptr_q + PW'(store_acc);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    st_rsp_d   = store_acc;
    state_d    = state_q;
    case (state_q)
      ST_IDLE: begin
        if (load_grant && dcache_data.addr_ok) state_d = ST_WAIT_LOAD;
        else if (pop)                          state_d = ST_WAIT_STORE;
      end
      ST_WAIT_LOAD, ST_WAIT_STORE: begin
        if (dcache_data.data_ok) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      state_q  <= ST_IDLE;
      st_rsp_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      state_q  <= state_d;
      st_rsp_q <= st_rsp_d;
    end
  end

  // Entry RAM carries no reset; liveness comes only from the pointers.
  always_ff @(posedge clk) begin
    if (store_acc) begin
      ent_addr_q[wr_idx]  <= cpu_data.addr;
      ent_wdata_q[wr_idx] <= cpu_data.wdata;
      ent_wstrb_q[wr_idx] <= cpu_data.wstrb;
      ent_size_q[wr_idx]  <= cpu_data.size;
    end
  end

  assign load_rsp = (state_q == ST_WAIT_LOAD) && dcache_data.data_ok;

  assign dcache_data.req   = load_grant | drain_go;
  assign dcache_data.wr    = drain_go;
  assign dcache_data.size  = load_grant ? cpu_data.size : ent_size_q[rd_idx];
  assign dcache_data.addr  = load_grant ? cpu_data.addr : ent_addr_q[rd_idx];
  assign dcache_data.wdata = load_grant ? '0 : ent_wdata_q[rd_idx];
  assign dcache_data.wstrb = load_grant ? 4'h0 : ent_wstrb_q[rd_idx];

  assign cpu_data.addr_ok = store_acc | (load_grant & dcache_data.addr_ok) | fwd_acc;

  assign sb_empty = (cnt == '0) && (state_q != ST_WAIT_STORE);
  assign sb_count = cnt;
endmodule
